// File: rtl/snd_pkg.sv
// Shared definitions for the send path: word and header layout, channel
// count, and the state encodings used by the per-channel block FIFOs.
package snd_pkg;

  localparam int WORD_W      = 16;
  localparam int NCHAN       = 17;

  localparam int HDR_FLAG    = 15;
  localparam int HDR_CHAN_HI = 14;
  localparam int HDR_CHAN_LO = 9;
  localparam int HDR_LEN_HI  = 8;
  localparam int HDR_LEN_LO  = 0;
  localparam int HDR_CHAN_W  = HDR_CHAN_HI - HDR_CHAN_LO + 1;
  localparam int HDR_LEN_W   = HDR_LEN_HI - HDR_LEN_LO + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RIDLE = 1'b0,
    SEND  = 1'b1
  } rd_state_e;

  // Replace the channel field of a header word.
  function automatic logic [WORD_W-1:0] set_hdr_chan(input logic [WORD_W-1:0] w,
                                                     input logic [HDR_CHAN_W-1:0] ch);
    logic [WORD_W-1:0] r;
    r = w;
    r[HDR_CHAN_HI:HDR_CHAN_LO] = ch;
    return r;
  endfunction

endpackage

// File: rtl/chan_blk_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// The read register has a synchronous reset so the FIFO output reads 0
// after reset; contents themselves are never cleared.
module chan_blk_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value while re is low.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/chan_blk_fifo.sv
// Per-channel block buffer in front of snd_arb. Blocks become visible to
// the reader only once complete; truncated or oversized blocks are rewound.
// Optional macro CHAN_BLK_FIFO_STAT_EN builds the saturating drop counter;
// without it drop_cnt is tied to 0.
//
// Write FSM
//   state | meaning
//   IDLE  | waiting for a header; stray data words are ignored
//   FILL  | header stored, 'remaining' data words still expected
//   DROP  | current block discarded, swallowing its remaining words
// Read FSM
//   state | meaning
//   RIDLE | no block in progress; fifo_have = committed data present
//   SEND  | block being streamed while arb_want is high
module chan_blk_fifo
  import snd_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int CHAN_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] din,
  input  logic              din_wr,
  input  logic              arb_want,
  output logic              fifo_have,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic [15:0]       drop_cnt
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0]         DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0]         PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [HDR_LEN_W-1:0]  LEN_ONE   = {{(HDR_LEN_W-1){1'b0}}, 1'b1};
  localparam logic [HDR_CHAN_W-1:0] CHAN_BITS = HDR_CHAN_W'(CHAN_ID);

  wr_state_e             wstate_q, wstate_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [HDR_LEN_W-1:0]  remaining_q, remaining_d;

  rd_state_e             rstate_q, rstate_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [HDR_LEN_W-1:0]  left_q, left_d;
  logic                  first_q, first_d;

  logic                  is_hdr;
  logic [HDR_LEN_W-1:0]  hdr_len;
  logic [HDR_LEN_W-1:0]  rem_dec;
  logic                  restart;
  logic                  wr_req;
  logic [PW-1:0]         wr_addr;
  logic                  wr_full;
  logic                  ram_we;
  logic [WORD_W-1:0]     ram_wdata;
  logic                  ram_re;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  have_blk;
  logic [HDR_LEN_W-1:0]  eff_left;

  assign is_hdr    = din[HDR_FLAG];
  assign hdr_len   = din[HDR_LEN_HI:HDR_LEN_LO];
  assign rem_dec   = remaining_q - LEN_ONE;
  // A header arriving mid-block restarts at the last commit point.
  assign restart   = din_wr & is_hdr & (wstate_q == FILL);
  assign wr_req    = din_wr & (is_hdr | (wstate_q == FILL));
  assign wr_addr   = restart ? commit_ptr_q : wr_ptr_q;
  // Checked against the actual write slot so a committed block is never hit.
  assign wr_full   = (wr_addr - rd_ptr_q) == DEPTH;
  assign ram_we    = wr_req & ~wr_full;
  assign ram_wdata = is_hdr ? set_hdr_chan(din, CHAN_BITS) : din;

  assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH;

  // Write-side next state: store, commit, rewind on truncation or overflow.
  always_comb begin
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    remaining_d  = remaining_q;
    if (din_wr) begin
      if (is_hdr) begin
        remaining_d = hdr_len;
        if (wr_full) begin
          wr_ptr_d = commit_ptr_q;
          wstate_d = (hdr_len != '0) ? DROP : IDLE;
        end else begin
          wr_ptr_d = wr_addr + PTR_ONE;
          if (hdr_len == '0) begin
            commit_ptr_d = wr_addr + PTR_ONE;
            wstate_d     = IDLE;
          end else begin
            wstate_d = FILL;
          end
        end
      end else begin
        case (wstate_q)
          FILL: begin
            remaining_d = rem_dec;
            if (wr_full) begin
              wr_ptr_d = commit_ptr_q;
              wstate_d = (rem_dec != '0) ? DROP : IDLE;
            end else begin
              wr_ptr_d = wr_addr + PTR_ONE;
              if (rem_dec == '0) begin
                commit_ptr_d = wr_addr + PTR_ONE;
                wstate_d     = IDLE;
              end
            end
          end
          DROP: begin
            remaining_d = rem_dec;
            if (rem_dec == '0) wstate_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign have_blk = commit_ptr_q != rd_ptr_q;
  // While the header sits in the read register its length field is the count.
  assign eff_left = first_q ? ram_rdata[HDR_LEN_HI:HDR_LEN_LO] : left_q;
  assign fifo_have = (rstate_q == SEND) ? (eff_left != '0) : have_blk;
  assign dout      = ram_rdata;

  // Read-side next state: one RAM read per granted cycle until the block ends.
  always_comb begin
    rstate_d = rstate_q;
    rd_ptr_d = rd_ptr_q;
    left_d   = left_q;
    first_d  = first_q;
    ram_re   = 1'b0;
    case (rstate_q)
      RIDLE: begin
        if (arb_want && have_blk) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          first_d  = 1'b1;
          rstate_d = SEND;
        end
      end
      SEND: begin
        if (eff_left == '0) begin
          first_d  = 1'b0;
          rstate_d = RIDLE;
        end else if (arb_want) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          left_d   = eff_left - LEN_ONE;
          first_d  = 1'b0;
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate_q     <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      remaining_q  <= '0;
      rstate_q     <= RIDLE;
      rd_ptr_q     <= '0;
      left_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      remaining_q  <= remaining_d;
      rstate_q     <= rstate_d;
      rd_ptr_q     <= rd_ptr_d;
      left_q       <= left_d;
      first_q      <= first_d;
    end
  end

`ifdef CHAN_BLK_FIFO_STAT_EN
  logic        ovf;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign ovf = wr_req & wr_full;

  // A header over a full buffer mid-block discards two blocks at once.
  always_comb begin
    drop_inc   = {1'b0, restart} + {1'b0, ovf};
    drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  chan_blk_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (wr_addr[ADDR_W-1:0]),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_chan_blk_fifo.sv
// Scoreboard bench for chan_blk_fifo (ADDR_W=3, CHAN_ID=5).
module tb_chan_blk_fifo;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        din_wr;
  logic        arb_want;
  logic        fifo_have;
  logic [15:0] dout;
  logic        full;
  logic [15:0] drop_cnt;

`ifdef CHAN_BLK_FIFO_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_drop = 0;
  logic [16:0] exp_q [$];   // {last, word}

  chan_blk_fifo #(.ADDR_W(3), .CHAN_ID(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_wr    (din_wr),
    .arb_want  (arb_want),
    .fifo_have (fifo_have),
    .dout      (dout),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_hdr(input logic [8:0] n);
    return {1'b1, 6'd5, n};
  endfunction

  task automatic wr(input logic [15:0] w);
    din    = w;
    din_wr = 1'b1;
    @(posedge clk); #1;
    din_wr = 1'b0;
  endtask

  // Write a block; header carries a foreign channel id that the DUT must replace.
  task automatic send_blk(input int n, input logic [14:0] base, input bit expect_ok);
    logic [14:0] dv;
    if (expect_ok) begin
      exp_q.push_back({(n == 0), exp_hdr(9'(n))});
      for (int k = 1; k <= n; k++) begin
        dv = base + 15'(k);
        exp_q.push_back({(k == n), 1'b0, dv});
      end
    end
    wr({1'b1, 6'd7, 9'(n)});
    for (int k = 1; k <= n; k++) begin
      dv = base + 15'(k);
      wr({1'b0, dv});
    end
  endtask

  // Act as the arbiter for one block, comparing each word with the scoreboard.
  task automatic recv_block(input int pause_at, input int reset_at);
    logic [16:0] e;
    bit done;
    int n;
    n = 0;
    while (fifo_have !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (fifo_have !== 1'b1) begin
      check("have_wait", {31'd0, fifo_have}, 1);
      return;
    end
    arb_want = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
        arb_want = 1'b0;
        return;
      end
      e = exp_q.pop_front();
      check("dout", {16'd0, dout}, {16'd0, e[15:0]});
      check("have", {31'd0, fifo_have}, {31'd0, !e[16]});
      if (e[16]) begin
        arb_want = 1'b0;
        done = 1'b1;
      end else if (i == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        arb_want = 1'b0;
        check("rst_have", {31'd0, fifo_have}, 0);
        check("rst_dout", {16'd0, dout}, 0);
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e[16]) break;
        end
        exp_drop = 0;
        done = 1'b1;
      end else if (i == pause_at) begin
        arb_want = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("hold_dout", {16'd0, dout}, {16'd0, e[15:0]});
          check("hold_have", {31'd0, fifo_have}, 1);
        end
        arb_want = 1'b1;
      end
    end
    if (!done) begin
      check("recv_timeout", 0, 1);
      arb_want = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    din      = '0;
    din_wr   = 1'b0;
    arb_want = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_have0", {31'd0, fifo_have}, 0);
    check("rst_dout0", {16'd0, dout}, 0);
    check("rst_full0", {31'd0, full}, 0);
    check("rst_drop0", {16'd0, drop_cnt}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single block, header rewritten to channel 5.
    exp_q.push_back({1'b0, 16'h8A03});
    exp_q.push_back({1'b0, 16'h0111});
    exp_q.push_back({1'b0, 16'h0222});
    exp_q.push_back({1'b1, 16'h0333});
    wr(16'h8E03);
    wr(16'h0111);
    wr(16'h0222);
    check("have_before_commit", {31'd0, fifo_have}, 0);
    wr(16'h0333);
    check("have_after_commit", {31'd0, fifo_have}, 1);
    recv_block(-1, -1);

    // Stray data in IDLE is ignored.
    wr(16'h0055);
    check("stray_have", {31'd0, fifo_have}, 0);

    // Truncation: first block abandoned, second delivered.
    wr(16'h8004);
    wr(16'h0aaa);
    wr(16'h0bbb);
    check("trunc_hidden", {31'd0, fifo_have}, 0);
    exp_drop++;
    send_blk(1, 15'h0100, 1'b1);
    recv_block(-1, -1);
    check("trunc_drop", {16'd0, drop_cnt}, STAT ? 32'(exp_drop) : 0);

    // Overflow: N=10 cannot fit into 8 words.
    wr(16'h800A);
    for (int k = 1; k <= 7; k++) wr(16'(16'h0200 + k));
    check("ovf_full", {31'd0, full}, 1);
    check("ovf_have_a", {31'd0, fifo_have}, 0);
    wr(16'h0208);
    check("ovf_rewind", {31'd0, full}, 0);
    wr(16'h0209);
    wr(16'h020A);
    check("ovf_have_b", {31'd0, fifo_have}, 0);
    exp_drop++;
    check("ovf_drop", {16'd0, drop_cnt}, STAT ? 32'(exp_drop) : 0);
    send_blk(2, 15'h0300, 1'b1);
    recv_block(-1, -1);

    // Pause after data word 2 of an N=5 block.
    send_blk(5, 15'h0400, 1'b1);
    recv_block(2, -1);

    // Back-to-back blocks, second written while the first is streamed.
    send_blk(2, 15'h0500, 1'b1);
    fork
      recv_block(-1, -1);
      send_blk(2, 15'h0600, 1'b1);
    join
    recv_block(-1, -1);

    // Reset during data word 2, then a fresh block.
    send_blk(3, 15'h0700, 1'b1);
    recv_block(-1, 2);
    check("post_rst_drop", {16'd0, drop_cnt}, 0);
    check("post_rst_full", {31'd0, full}, 0);
    send_blk(1, 15'h0800, 1'b1);
    recv_block(-1, -1);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_blk_fifo.md
Name: chan_blk_fifo

Overview:
- Per-channel block buffer directly upstream of snd_arb; 17 instances, one per channel.
- Accepts 16-bit block words from channel processing, stores them, and holds back any block until it is complete.
- Raises fifo_have to request arbitration, then streams exactly one block on dout while arb_want is high.
- Block format:
  - Header word: bit15=1, [14:9]=channel id, [8:0]=N, the number of data words that follow.
  - Data words: N words, each with bit15=0.

Parameters:
- ADDR_W, 10: buffer depth is 2**ADDR_W words.
- CHAN_ID, 0: channel number; overwrites header bits [14:9] on write.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- din  in  16  block word from channel processing.
- din_wr  in  1  write strobe for din.
- arb_want  in  1  grant from snd_arb; held high for the whole block.
- fifo_have  out  1  a complete block is available or is being sent.
- dout  out  16  word to snd_arb (datain slice).
- full  out  1  no free word.
- drop_cnt  out  16  dropped-block counter (see Optional Feature).

Behaviour:
- Pointers:
  - wr_ptr: write position.
  - commit_ptr: end of the last complete block.
  - rd_ptr: read position.
  - All ADDR_W+1 bits with wrap bit; full when wr_ptr - rd_ptr == 2**ADDR_W.
- Reset (rst_n=0 at a clk edge):
  - All pointers 0; fifo_have=0; dout=0; full=0; drop_cnt=0; write FSM to IDLE.
  - A block in flight is abandoned. The arbiter observes fifo_have=0 on the next cycle.
- Write FSM: IDLE, FILL, DROP.
  - IDLE:
    - din_wr with bit15=1: write header with [14:9]=CHAN_ID; load remaining=N.
    - Go to FILL if N>0. If N=0, commit immediately and stay in IDLE.
    - din_wr with bit15=0: ignore the word silently (no count).
  - FILL:
    - Data word: write it, decrement remaining. When it reaches 0, set commit_ptr<=wr_ptr+1 and go to IDLE.
    - Header word: rewind wr_ptr to commit_ptr, count a drop, restart with the new header in the same cycle.
  - Full on any write:
    - Rewind wr_ptr to commit_ptr and count a drop.
    - Go to DROP if the remainder is still pending, else IDLE.
  - DROP: discard words until remaining reaches 0 or a header arrives (header is treated as in IDLE).
  - A committed block is never partially overwritten. Uncommitted data is never visible to the reader.
- Read side, states RIDLE, SEND:
  - fifo_have=1 in RIDLE whenever commit_ptr != rd_ptr.
  - In SEND, fifo_have stays 1 until the last word.
  - First arb_want cycle: RAM read of header issued; dout = header at grant+1.
  - Each further arb_want cycle advances one word. Data word k appears at grant+1+k.
  - fifo_have is driven 0 in the same cycle the last word is on dout. rd_ptr then points at the next block.
  - arb_want dropped mid-block: freeze rd_ptr and dout. Resume on the next arb_want with no word skipped or repeated.
  - Both pointers equal to commit_ptr: fifo_have=0, dout holds its last value.
- Simultaneous write and read in the same cycle is fully supported. full uses the pre-read rd_ptr (conservative).
- drop_cnt saturates at 16'hFFFF.

Optional Feature:
- Macro CHAN_BLK_FIFO_STAT_EN.
- Defined: drop_cnt counts every discarded block (overflow or truncation) and saturates.
- Undefined: drop_cnt is tied to 0 and the counter logic is not built. Drop behaviour is otherwise identical.

Decomposition:
- Package snd_pkg:
  - WORD_W=16, NCHAN=17.
  - Header field positions: HDR_FLAG=15, HDR_CHAN 14:9, HDR_LEN 8:0.
  - Write-state enum, read-state enum.
- Sub-module chan_blk_ram: simple dual-port RAM, one write port, one registered read port, depth 2**ADDR_W. Infers block RAM.

Test Plan:
- Single block: write header N=3 plus 3 data words, CHAN_ID=5.
  - fifo_have rises the cycle after the 4th write.
  - Grant → dout = 16'h8A03 then 3 data words.
  - fifo_have=0 with the last word.
- Truncation: header N=4, 2 data words, then a new header N=1 plus 1 word.
  - Only the second block is sent; drop_cnt=1 (macro on) / 0 (macro off).
- Overflow: ADDR_W=3, a block N=10 is written.
  - The block is dropped; fifo_have stays 0; full deasserts after the rewind.
  - A following N=2 block is sent intact.
- Pause: arb_want low for 3 cycles after the 2nd word of an N=5 block.
  - Output resumes at word 3 with no duplicate.
- Back-to-back: two committed N=2 blocks.
  - fifo_have drops for ≥1 cycle between them; the second is sent on re-grant.
- Reset mid-send: rst_n low during word 2.
  - Next cycle fifo_have=0, dout=0.
  - A fresh block written after reset is sent correctly.
